// File: rtl/fp_mul_pkg.sv
// Shared widths and types for the FP multiply mantissa path.
package fp_mul_pkg;
    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_e;
    typedef logic [MANT_W-1:0] mant_t;
    typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/add_24bits.sv
// 24-bit ripple adder with carry in/out, shared by the shift-and-add multiplier.
module add_24bits (
    input  logic [23:0] i_a,
    input  logic [23:0] i_b,
    input  logic        i_carry,
    output logic [23:0] o_sum,
    output logic        o_carry
);
    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {24'd0, i_carry};
endmodule

// File: rtl/mant_mul_seq_ctrl.sv
// Sequential 24x24 mantissa multiplier: one shared adder, 24 shift-and-add steps,
// valid/ready on both sides, one operation in flight.
module mant_mul_seq_ctrl
    import fp_mul_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [MANT_W-1:0] i_mant_a,
    input  logic [MANT_W-1:0] i_mant_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [PROD_W-1:0] o_product,
    output logic              o_busy
);
    mul_state_e       state, next_state;
    mant_t            mcand, hi, lo, sum, addend;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             last_iter;
    prod_t            next_hilo;
    prod_t            prod;

    // Multiplier bit 0 selects whether the multiplicand joins the partial sum.
    assign addend    = lo[0] ? mcand : '0;
    assign last_iter = (cnt == CNT_W'(MANT_W - 1));
    assign next_hilo = {c, sum, lo[MANT_W-1:1]};

    add_24bits u_add (
        .i_a     (hi),
        .i_b     (addend),
        .i_carry (1'b0),
        .o_sum   (sum),
        .o_carry (c)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_valid) next_state = RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    if (i_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            prod  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (i_valid) begin
                    mcand <= i_mant_a;
                    lo    <= i_mant_b;
                    hi    <= '0;
                    cnt   <= '0;
                end
                RUN: begin
                    {hi, lo} <= next_hilo;
                    cnt      <= cnt + 1'b1;
                    // Product register only moves on entry to DONE so it holds under backpressure.
                    if (last_iter) prod <= next_hilo;
                end
                default: ;
            endcase
        end
    end

    assign o_ready   = (state == IDLE);
    assign o_valid   = (state == DONE);
    assign o_busy    = (state != IDLE);
    assign o_product = prod;
endmodule
